goe_network: RTL and testbench

- Generates the six global output-enable lines `goe[0:5]` that every macrocell's output-enable selector consumes.
- Each line picks one of eight sources under fuse control: dedicated OE pins, I/O pins, or product terms.
- Each line has optional polarity inversion, is brought into the simulation clock domain through a 2-flop synchroniser, and can be passed through a programmable glitch filter.
- Sits between the pin/product-term array and the per-macrocell OE selectors.

---
 rtl/goe_pkg.sv | 31 +++
 rtl/goe_network_if.sv | 27 ++
 rtl/goe_line_filter.sv | 68 ++++++
 rtl/goe_network.sv | 38 +++
 tb/tb_goe_network.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/goe_pkg.sv
// Shared constants, FSM encoding and source indices for the global OE network.
// No logic of its own; zero latency.
// No flow control: everything here is configuration, not traffic.
package goe_pkg;

  localparam int NUM_GOE = 6;
  localparam int NUM_SRC = 8;
  localparam int SEL_W   = 3;
  localparam int FILT_W  = 3;

  typedef enum logic [0:0] {
    GOE_STABLE  = 1'b0,
    GOE_PENDING = 1'b1
  } goe_state_e;

  // Source indices as seen on goe_src: six dedicated/I-O pins, two OE product terms.
  localparam logic [SEL_W-1:0] GOE_SRC_PIN0 = 3'd0;
  localparam logic [SEL_W-1:0] GOE_SRC_PIN1 = 3'd1;
  localparam logic [SEL_W-1:0] GOE_SRC_PIN2 = 3'd2;
  localparam logic [SEL_W-1:0] GOE_SRC_PIN3 = 3'd3;
  localparam logic [SEL_W-1:0] GOE_SRC_PIN4 = 3'd4;
  localparam logic [SEL_W-1:0] GOE_SRC_PIN5 = 3'd5;
  localparam logic [SEL_W-1:0] GOE_SRC_PT0  = 3'd6;
  localparam logic [SEL_W-1:0] GOE_SRC_PT1  = 3'd7;

  // A programmed length of 0 means the same as 1 (no extra filtering).
  function automatic logic [FILT_W-1:0] goe_eff_len(input logic [FILT_W-1:0] len);
    return (len == '0) ? FILT_W'(1) : len;
  endfunction

endpackage

// File: rtl/goe_network_if.sv
// Bundles the source pins, fuse configuration and OE outputs of the GOE network.
// Pure wiring; zero latency.
// No flow control: every signal is a level sampled each clock.
interface goe_network_if;
  import goe_pkg::*;

  logic [0:NUM_SRC-1]       goe_src;
  logic [0:NUM_GOE*SEL_W-1] cfg_sel;
  logic [0:NUM_GOE-1]       cfg_inv;
  logic [0:NUM_GOE-1]       cfg_filt_en;
  logic [FILT_W-1:0]        cfg_filt_len;
  logic [0:NUM_GOE-1]       goe;
  logic [0:NUM_GOE-1]       goe_pending;

  // The master supplies pins and fuses and observes the OE lines.
  modport master (
    output goe_src, cfg_sel, cfg_inv, cfg_filt_en, cfg_filt_len,
    input  goe, goe_pending
  );

  // The slave is the network itself.
  modport slave (
    input  goe_src, cfg_sel, cfg_inv, cfg_filt_en, cfg_filt_len,
    output goe, goe_pending
  );

endinterface

// File: rtl/goe_line_filter.sv
// One OE line: 2-flop synchroniser, optional glitch filter FSM, output register.
// Latency raw->out is 3 edges unfiltered, 2+L edges filtered (L = max(len,1)).
// No backpressure: a level is sampled every edge; short glitches are dropped.
module goe_line_filter
  import goe_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              raw,
  input  logic              filt_en,
  input  logic [FILT_W-1:0] filt_len,
  output logic              out,
  output logic              pending
);

  localparam logic [0:0] ST_STABLE  = GOE_STABLE;
  localparam logic [0:0] ST_PENDING = GOE_PENDING;

  logic              s1;
  logic              s2;
  logic              out_q;
  logic [0:0]        state;
  logic [FILT_W-1:0] cnt;
  logic [FILT_W-1:0] last_cnt;

  // The edge on which cnt equals L-1 is the L-th consecutive edge seeing the
  // change. Using >= lets a shortened length commit at once, and cnt is only
  // ever incremented while below L-1, so it can neither overshoot nor wrap.
  assign last_cnt = goe_eff_len(filt_len) - 1'b1;

  // Synchroniser, filter FSM, counter and output register; reset wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      out_q <= 1'b0;
      cnt   <= '0;
      state <= ST_STABLE;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (!filt_en) begin
        // Bypass also cleans up a filter that was mid-count when disabled.
        out_q <= s2;
        cnt   <= '0;
        state <= ST_STABLE;
      end else if (s2 != out_q) begin
        // In STABLE cnt is 0, so the same test covers L=1 committing immediately.
        if (cnt >= last_cnt) begin
          out_q <= s2;
          cnt   <= '0;
          state <= ST_STABLE;
        end else begin
          cnt   <= cnt + 1'b1;
          state <= ST_PENDING;
        end
      end else begin
        // Either idle, or the glitch ended before being accepted.
        cnt   <= '0;
        state <= ST_STABLE;
      end
    end
  end

  assign out     = out_q;
  assign pending = (state == ST_PENDING);

endmodule

// File: rtl/goe_network.sv
// Six global OE lines: per-line source mux and polarity invert, then sync/filter.
// Latency source->goe is 3 edges unfiltered, 2+L edges when filtered.
// No backpressure: levels in, levels out, every line independent.
module goe_network
  import goe_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  goe_network_if.slave  bus
);

  logic [0:NUM_GOE-1] goe_v;
  logic [0:NUM_GOE-1] pend_v;

  for (genvar i = 0; i < NUM_GOE; i++) begin : g_line
    logic [SEL_W-1:0] sel;
    logic             raw;

    // Selection and inversion are combinational so fuse edits go through the
    // synchroniser exactly like pin changes.
    assign sel = bus.cfg_sel[i*SEL_W +: SEL_W];
    assign raw = bus.goe_src[sel] ^ bus.cfg_inv[i];

    goe_line_filter u_line (
      .clk      (clk),
      .rst      (rst),
      .raw      (raw),
      .filt_en  (bus.cfg_filt_en[i]),
      .filt_len (bus.cfg_filt_len),
      .out      (goe_v[i]),
      .pending  (pend_v[i])
    );
  end

  assign bus.goe         = goe_v;
  assign bus.goe_pending = pend_v;

endmodule

// File: tb/tb_goe_network.sv
// Directed bench for goe_network: reset, latency/invert, filter reject/accept,
// zero length, reset mid-filter, filter disable and length change mid-filter.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_goe_network;
  import goe_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  goe_network_if bus ();

  goe_network dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its hand-computed expectation.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, leaving time 1 unit past the last edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;

    // ---- reset with every source high, line i selecting source i ----
    rst                  = 1'b1;
    bus.goe_src          = 8'hFF;
    bus.cfg_inv          = '0;
    bus.cfg_filt_en      = '0;
    bus.cfg_filt_len     = 3'd0;
    for (int i = 0; i < NUM_GOE; i++) bus.cfg_sel[i*SEL_W +: SEL_W] = 3'(i);
    tick(1);
    chk("rst_goe_a", 32'(bus.goe), 32'h0);
    chk("rst_pend_a", 32'(bus.goe_pending), 32'h0);
    tick(1);
    chk("rst_goe_b", 32'(bus.goe), 32'h0);
    chk("rst_pend_b", 32'(bus.goe_pending), 32'h0);
    rst = 1'b0;
    tick(1);
    chk("rel_e1", 32'(bus.goe), 32'h0);
    tick(1);
    chk("rel_e2", 32'(bus.goe), 32'h0);
    tick(1);
    chk("rel_e3", 32'(bus.goe), 32'h3F);

    // ---- unfiltered latency with inversion on line 0 ----
    bus.goe_src[3]   = 1'b0;
    bus.cfg_sel[0:2] = 3'd3;   // line 0 <- source 3
    bus.cfg_sel[9:11] = 3'd7;  // move line 3 off source 3
    bus.cfg_inv[0]   = 1'b1;
    tick(4);
    chk("inv_settle", 32'(bus.goe), 32'h3F);
    bus.goe_src[3] = 1'b1;
    tick(1);
    chk("inv_e1", 32'(bus.goe), 32'h3F);
    tick(1);
    chk("inv_e2", 32'(bus.goe), 32'h3F);
    tick(1);
    chk("inv_e3", 32'(bus.goe), 32'(6'b011111));
    chk("inv_pend", 32'(bus.goe_pending), 32'h0);

    // ---- filter reject: line 2, L=4, 3-cycle high pulse ----
    bus.goe_src[2]   = 1'b0;
    bus.cfg_filt_len = 3'd4;
    tick(4);
    chk("flt_base", 32'(bus.goe), 32'(6'b010111));
    bus.cfg_filt_en[2] = 1'b1;
    tick(2);
    chk("flt_en_stable", 32'(bus.goe_pending), 32'h0);
    bus.goe_src[2] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      chk($sformatf("rej_pend_%0d", k), 32'(bus.goe_pending[2]), 32'((k >= 3 && k <= 5) ? 1 : 0));
      chk($sformatf("rej_goe_%0d", k), 32'(bus.goe), 32'(6'b010111));
      if (k == 3) bus.goe_src[2] = 1'b0;
    end

    // ---- filter accept: 5-cycle pulse, rise on edge 6, fall 6 edges after end ----
    bus.goe_src[2] = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      tick(1);
      chk($sformatf("acc_goe_%0d", k), 32'(bus.goe[2]), 32'((k >= 6 && k <= 10) ? 1 : 0));
      chk($sformatf("acc_pend_%0d", k), 32'(bus.goe_pending[2]),
          32'(((k >= 3 && k <= 5) || (k >= 8 && k <= 10)) ? 1 : 0));
      if (k == 5) bus.goe_src[2] = 1'b0;
    end

    // ---- zero length behaves like unfiltered: 1-cycle pulse ----
    bus.cfg_filt_len = 3'd0;
    bus.goe_src[2]   = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick(1);
      chk($sformatf("len0_goe_%0d", k), 32'(bus.goe[2]), 32'((k == 3) ? 1 : 0));
      chk($sformatf("len0_pend_%0d", k), 32'(bus.goe_pending[2]), 32'h0);
      if (k == 1) bus.goe_src[2] = 1'b0;
    end

    // ---- reset while line 1 is pending with cnt=2 ----
    bus.cfg_filt_len   = 3'd4;
    bus.cfg_filt_en[1] = 1'b1;
    tick(1);
    bus.goe_src[1] = 1'b0;
    tick(4);
    chk("mid_pend_before", 32'(bus.goe_pending[1]), 32'h1);
    chk("mid_goe_before", 32'(bus.goe[1]), 32'h1);
    rst = 1'b1;
    tick(1);
    chk("mid_rst_pend", 32'(bus.goe_pending), 32'h0);
    chk("mid_rst_goe", 32'(bus.goe), 32'h0);
    rst                = 1'b0;
    bus.goe_src[1]     = 1'b1;
    bus.cfg_filt_en    = '0;
    tick(4);
    chk("post_rst_settle", 32'(bus.goe), 32'(6'b010111));

    // ---- filter disabled mid-pending: adopt s2 on next edge ----
    bus.cfg_filt_en[1] = 1'b1;
    tick(1);
    bus.goe_src[1] = 1'b0;
    tick(4);
    chk("drop_pend_before", 32'(bus.goe_pending[1]), 32'h1);
    chk("drop_goe_before", 32'(bus.goe[1]), 32'h1);
    bus.cfg_filt_en[1] = 1'b0;
    tick(1);
    chk("drop_goe_after", 32'(bus.goe[1]), 32'h0);
    chk("drop_pend_after", 32'(bus.goe_pending[1]), 32'h0);

    // ---- length shortened mid-pending: commits on next edge ----
    bus.cfg_filt_en[1] = 1'b1;
    tick(1);
    bus.goe_src[1] = 1'b1;
    tick(4);
    chk("shrink_pend_before", 32'(bus.goe_pending[1]), 32'h1);
    chk("shrink_goe_before", 32'(bus.goe[1]), 32'h0);
    bus.cfg_filt_len = 3'd2;
    tick(1);
    chk("shrink_goe_after", 32'(bus.goe[1]), 32'h1);
    chk("shrink_pend_after", 32'(bus.goe_pending[1]), 32'h0);
    chk("shrink_others", 32'(bus.goe), 32'(6'b010111));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
